// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the architectural PC and the IF/ID register, and
// handles redirects, hazard stalls, instruction-memory wait states and HALT.
module fetch_pc_unit #(
   parameter logic [15:0] NOP_INSTR = 16'h0800,
   parameter logic [4:0]  HALT_OP   = 5'b00000,
   parameter logic [15:0] RESET_PC  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        redirect,
   input  logic        pc_jump_B_sel,
   input  logic [15:0] ex_pc_plus2,
   input  logic [15:0] ex_rs,
   input  logic [15:0] ex_disp,
   output logic [15:0] pc,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc_plus2,
   output logic        ifid_valid,
   output logic        halted,
   output logic        misalign_err
);

   typedef enum logic [1:0] {RUN = 2'd0, WAIT_MEM = 2'd1, HALTED = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc2_q, pc2_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;
   logic [15:0] target;
   logic [15:0] pc_plus2;

   assign target   = (pc_jump_B_sel ? ex_pc_plus2 : ex_rs) + ex_disp;
   assign pc_plus2 = pc_q + 16'd2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pc2_q   <= 16'h0000;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc2_q   <= pc2_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   // Redirect outranks stall so a resolved branch never waits behind a hazard.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc2_d   = pc2_q;
      valid_d = valid_q;
      mis_d   = mis_q | (redirect & target[0]);
      if (redirect) begin
         state_d = RUN;
         pc_d    = target;
         instr_d = NOP_INSTR;
         pc2_d   = 16'h0000;
         valid_d = 1'b0;
      end else if (stall) begin
         state_d = state_q;
      end else if (state_q == HALTED) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (!imem_ready) begin
         state_d = WAIT_MEM;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else begin
         instr_d = imem_data;
         pc2_d   = pc_plus2;
         valid_d = 1'b1;
         if (imem_data[15:11] == HALT_OP) begin
            state_d = HALTED;
         end else begin
            state_d = RUN;
            pc_d    = pc_plus2;
         end
      end
   end

   always_comb begin
      imem_addr     = pc_q;
      pc            = pc_q;
      ifid_instr    = instr_q;
      ifid_pc_plus2 = pc2_q;
      ifid_valid    = valid_q;
      halted        = (state_q == HALTED);
      misalign_err  = mis_q;
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a
// behavioural model of the fetch PC / IF/ID rules.
module tb_fetch_pc_unit;
   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_addr, imem_data;
   logic        imem_ready, stall, redirect, pc_jump_B_sel;
   logic [15:0] ex_pc_plus2, ex_rs, ex_disp;
   logic [15:0] pc, ifid_instr, ifid_pc_plus2;
   logic        ifid_valid, halted, misalign_err;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   logic [15:0] m_pc, m_instr, m_pc2;
   logic        m_valid, m_halted, m_mis;

   fetch_pc_unit dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .imem_ready(imem_ready), .stall(stall), .redirect(redirect),
      .pc_jump_B_sel(pc_jump_B_sel), .ex_pc_plus2(ex_pc_plus2), .ex_rs(ex_rs),
      .ex_disp(ex_disp), .pc(pc), .ifid_instr(ifid_instr),
      .ifid_pc_plus2(ifid_pc_plus2), .ifid_valid(ifid_valid), .halted(halted),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = NOP; m_pc2 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
   endtask

   task automatic model_clk();
      logic [15:0] tgt;
      tgt = (pc_jump_B_sel ? ex_pc_plus2 : ex_rs) + ex_disp;
      if (redirect) begin
         if (tgt[0]) m_mis = 1'b1;
         m_pc = tgt; m_instr = NOP; m_pc2 = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
      end else if (stall) begin
         m_valid = m_valid;
      end else if (m_halted || !imem_ready) begin
         m_instr = NOP; m_valid = 1'b0;
      end else begin
         m_instr = imem_data; m_pc2 = m_pc + 16'd2; m_valid = 1'b1;
         if (imem_data[15:11] == 5'd0) m_halted = 1'b1;
         else m_pc = m_pc + 16'd2;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_pc"}, pc, m_pc);
      chk({tag, "_addr"}, imem_addr, m_pc);
      chk({tag, "_instr"}, ifid_instr, m_instr);
      chk({tag, "_valid"}, {15'd0, ifid_valid}, {15'd0, m_valid});
      chk({tag, "_halted"}, {15'd0, halted}, {15'd0, m_halted});
      chk({tag, "_mis"}, {15'd0, misalign_err}, {15'd0, m_mis});
      if (m_valid) chk({tag, "_pc2"}, ifid_pc_plus2, m_pc2);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_clk();
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      imem_ready = 1'b0; imem_data = 16'h4000; stall = 1'b0; redirect = 1'b0;
      pc_jump_B_sel = 1'b0; ex_pc_plus2 = 16'h0000; ex_rs = 16'h0000; ex_disp = 16'h0000;
   endtask

   task automatic jump_to(input logic [15:0] a, input string tag);
      idle();
      redirect = 1'b1; ex_rs = a;
      step(tag);
      redirect = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pc"}, pc, 16'h0000);
      chk({tag, "_addr"}, imem_addr, 16'h0000);
      chk({tag, "_instr"}, ifid_instr, NOP);
      chk({tag, "_pc2"}, ifid_pc_plus2, 16'h0000);
      chk({tag, "_valid"}, {15'd0, ifid_valid}, 16'h0000);
      chk({tag, "_halted"}, {15'd0, halted}, 16'h0000);
      chk({tag, "_mis"}, {15'd0, misalign_err}, 16'h0000);
   endtask

   initial begin
      idle();
      rst = 1'b0;
      model_reset();
      #12;
      check_reset_vals("rst");
      @(negedge clk) rst = 1'b1;

      // 1: sequential fetch
      imem_ready = 1'b1; imem_data = 16'h4000;
      for (int i = 1; i <= 3; i++) begin
         step("seq");
         chk("seq_pc_const", pc, 16'(2 * i));
         chk("seq_pc2_const", ifid_pc_plus2, 16'(2 * i));
      end

      // 2: PC-relative redirect
      idle();
      redirect = 1'b1; pc_jump_B_sel = 1'b1; ex_pc_plus2 = 16'h0010; ex_disp = 16'hFFF8;
      step("br");
      chk("br_pc_const", pc, 16'h0008);
      chk("br_instr_const", ifid_instr, 16'h0800);

      // 3: register-based redirect beats stall; odd target sets sticky error
      idle();
      redirect = 1'b1; stall = 1'b1; ex_rs = 16'h1234; ex_disp = 16'h0002;
      step("jr");
      chk("jr_pc_const", pc, 16'h1236);
      ex_rs = 16'h1235;
      step("jr_odd");
      chk("jr_mis_const", {15'd0, misalign_err}, 16'h0001);
      idle(); imem_ready = 1'b1;
      step("jr_sticky");
      stall = 1'b1;
      step("stall_hold");

      // 4: memory wait states
      jump_to(16'h0020, "w_j");
      imem_ready = 1'b0;
      step("w0"); step("w1");
      chk("w_pc_const", pc, 16'h0020);
      imem_ready = 1'b1; imem_data = 16'hA1B2;
      step("w2");
      chk("w_instr_const", ifid_instr, 16'hA1B2);
      chk("w_pc2_const", ifid_pc_plus2, 16'h0022);

      // 5: HALT and resume via redirect
      jump_to(16'h0030, "h_j");
      imem_ready = 1'b1; imem_data = 16'h0000;
      step("h0");
      imem_data = 16'h4000;
      step("h1"); step("h2");
      chk("h_pc_const", pc, 16'h0030);
      chk("h_halt_const", {15'd0, halted}, 16'h0001);
      jump_to(16'h0040, "h_res");
      imem_ready = 1'b1;
      step("h_run");
      chk("h_resume_pc2", ifid_pc_plus2, 16'h0042);

      // 6: wrap and asynchronous reset mid-wait
      jump_to(16'hFFFE, "wr_j");
      imem_ready = 1'b1;
      step("wrap");
      chk("wrap_pc_const", pc, 16'h0000);
      jump_to(16'h0050, "ar_j");
      imem_ready = 1'b0;
      step("ar_wait");
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_reset_vals("arst");
      @(negedge clk) rst = 1'b1;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         redirect      = ($urandom_range(0, 9) == 0);
         stall         = ($urandom_range(0, 6) == 0);
         imem_ready    = ($urandom_range(0, 9) < 7);
         imem_data     = 16'($urandom);
         pc_jump_B_sel = 1'($urandom);
         ex_pc_plus2   = 16'($urandom);
         ex_rs         = 16'($urandom) & 16'hFFFE;
         ex_disp       = ($urandom_range(0, 15) == 0) ? 16'h0001 : (16'($urandom) & 16'hFFFE);
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
